// File: rtl/sram_if_pkg.sv
// Shared types for the data-SRAM responder: size encodings, response FIFO entry,
// byte-lane merge and the LFSR step used when DATA_SRAM_RANDOM_DELAY_EN is defined.
package sram_if_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    localparam int          CNT_W     = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic             wr;
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
    } resp_entry_t;

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Maximal-length x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response FIFO; every entry carries its own latency down-counter and
// the head is ready to retire once its counter has reached zero.
module resp_fifo
    import sram_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  resp_entry_t            i_entry,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_head_wr,
    output logic [31:0]            o_head_data,
    output logic                   o_head_ready
);
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    resp_entry_t      r_slot [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;
    resp_entry_t      w_head;

    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop && o_head_ready;

    // Slot storage: load on push, otherwise every counter runs down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_slot[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (w_push && (r_wr_ptr == PTR_W'(s))) begin
                    r_slot[s] <= i_entry;
                end else if (r_slot[s].cnt != '0) begin
                    r_slot[s].cnt <= r_slot[s].cnt - CNT_W'(1);
                end
            end
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head       = r_slot[r_rd_ptr];
    assign o_head_ready = (r_count != '0) && (w_head.cnt == '0);
    assign o_head_wr    = w_head.wr;
    assign o_head_data  = w_head.data;
    assign o_count      = r_count;

endmodule

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word memory answering sram-like req/addr_ok/data_ok in order.
// Optional feature macro: DATA_SRAM_RANDOM_DELAY_EN (LFSR-driven extra latency and addr_ok stalls).
module data_sram_responder
    import sram_if_pkg::*;
#(
    parameter int MEM_AW     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int LATENCY    = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        req,
    input  logic                        wr,
    input  logic [1:0]                  size,
    input  logic [3:0]                  wstrb,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 wdata,
    output logic                        addr_ok,
    output logic                        data_ok,
    output logic [31:0]                 rdata,
    output logic [$clog2(FIFO_DEPTH):0] outstanding
);
    localparam int                        OCC_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0]          FULL_CNT = OCC_W'(FIFO_DEPTH);

    logic [31:0]       r_mem [2**MEM_AW];
    logic [MEM_AW-1:0] w_idx;
    logic              w_fire;
    logic              w_full;
    logic [OCC_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_init_cnt;
    resp_entry_t       w_push_entry;
    logic              w_head_wr;
    logic [31:0]       w_head_data;
    logic              w_head_ready;
    logic              w_unused;

    // Size and the out-of-range/byte-offset address bits are carried only.
    assign w_unused = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    assign w_idx  = addr[MEM_AW+1:2];
    assign w_full = (w_count == FULL_CNT);
    assign w_fire = req && addr_ok;

`ifdef DATA_SRAM_RANDOM_DELAY_EN
    logic [15:0] r_lfsr;

    // Free-running LFSR: low bits stretch latency, bits [5:4] stall acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign addr_ok    = !w_full && (r_lfsr[5:4] != 2'b11);
    assign w_init_cnt = CNT_W'(LATENCY - 1) + CNT_W'(r_lfsr[1:0]);
`else
    assign addr_ok    = !w_full;
    assign w_init_cnt = CNT_W'(LATENCY - 1);
`endif

    // Memory is deliberately not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (w_fire && wr) begin
            r_mem[w_idx] <= merge_bytes(r_mem[w_idx], wdata, wstrb);
        end
    end

    // Entry pushed on acceptance: reads capture the word now, writes respond with zero.
    always_comb begin
        w_push_entry     = '0;
        w_push_entry.cnt = w_init_cnt;
        if (wr) begin
            w_push_entry.wr   = 1'b1;
            w_push_entry.data = 32'h0000_0000;
        end else begin
            w_push_entry.wr   = 1'b0;
            w_push_entry.data = r_mem[w_idx];
        end
    end

    resp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk          (clk),
        .rst_n        (resetn),
        .i_push       (w_fire),
        .i_entry      (w_push_entry),
        .i_pop        (w_head_ready),
        .o_count      (w_count),
        .o_head_wr    (w_head_wr),
        .o_head_data  (w_head_data),
        .o_head_ready (w_head_ready)
    );

    // Response data is forced to zero outside a read pulse.
    always_comb begin
        if (w_head_ready && !w_head_wr) begin
            rdata = w_head_data;
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    assign data_ok     = w_head_ready;
    assign outstanding = w_count;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (LATENCY 1/3/5, depth 4) checked
// every cycle against a due-time response queue model plus literal expectations.
module tb_data_sram_responder;
    localparam int NI    = 3;
    localparam int DEPTH = 4;
    localparam int LAT [NI] = '{1, 3, 5};

    logic        clk = 1'b0;
    logic        resetn;
    logic        t_req   [NI];
    logic        t_wr    [NI];
    logic [1:0]  t_size  [NI];
    logic [3:0]  t_wstrb [NI];
    logic [31:0] t_addr  [NI];
    logic [31:0] t_wdata [NI];
    logic        w_aok   [NI];
    logic        w_dok   [NI];
    logic [31:0] w_rdata [NI];
    logic [2:0]  w_out   [NI];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          q_due [NI][$];
    logic [31:0] q_dat [NI][$];
    logic [31:0] rlog  [NI][$];
    int          clog  [NI][$];
    int          n_acc   [NI];
    int          n_pulse [NI];
    int          n_drop  [NI];
    logic [31:0] ref_mem [NI][4096];
    logic        b_aok [40];
    logic        b_dok [40];
    int          b_out [40];
    bit          fire;
    bit          pop;
    int          idx;
`ifndef DATA_SRAM_RANDOM_DELAY_EN
    bit          e_aok;
    bit          e_dok;
`endif
    int          base;
    int          p;
    logic [31:0] ra;

    always #5 clk = ~clk;

    data_sram_responder #(.MEM_AW(12), .FIFO_DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
        .clk(clk), .resetn(resetn), .req(t_req[0]), .wr(t_wr[0]), .size(t_size[0]),
        .wstrb(t_wstrb[0]), .addr(t_addr[0]), .wdata(t_wdata[0]), .addr_ok(w_aok[0]),
        .data_ok(w_dok[0]), .rdata(w_rdata[0]), .outstanding(w_out[0]));

    data_sram_responder #(.MEM_AW(12), .FIFO_DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk(clk), .resetn(resetn), .req(t_req[1]), .wr(t_wr[1]), .size(t_size[1]),
        .wstrb(t_wstrb[1]), .addr(t_addr[1]), .wdata(t_wdata[1]), .addr_ok(w_aok[1]),
        .data_ok(w_dok[1]), .rdata(w_rdata[1]), .outstanding(w_out[1]));

    data_sram_responder #(.MEM_AW(12), .FIFO_DEPTH(DEPTH), .LATENCY(5)) u_lat5 (
        .clk(clk), .resetn(resetn), .req(t_req[2]), .wr(t_wr[2]), .size(t_size[2]),
        .wstrb(t_wstrb[2]), .addr(t_addr[2]), .wdata(t_wdata[2]), .addr_ok(w_aok[2]),
        .data_ok(w_dok[2]), .rdata(w_rdata[2]), .outstanding(w_out[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each accepted request is due LATENCY cycles after acceptance, and
    // retires at the first cycle it is both due and at the front of the queue.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (resetn) begin
            for (int i = 0; i < NI; i++) begin
                chk("outstanding", 32'(w_out[i]), 32'(q_due[i].size()));
`ifdef DATA_SRAM_RANDOM_DELAY_EN
                fire = t_req[i] && w_aok[i];
                pop  = 1'b0;
                chk("addr_ok_when_full", 32'(w_aok[i] && (q_due[i].size() == DEPTH)), 32'd0);
                if (w_dok[i]) begin
                    if (q_due[i].size() == 0) begin
                        chk("data_ok_extra", 32'd1, 32'd0);
                    end else begin
                        chk("rdata", w_rdata[i], q_dat[i][0]);
                        chk("data_ok_early", 32'(q_due[i][0] <= cyc), 32'd1);
                        pop = 1'b1;
                    end
                end else begin
                    chk("rdata_idle", w_rdata[i], 32'd0);
                end
`else
                e_aok = (q_due[i].size() != DEPTH);
                e_dok = (q_due[i].size() != 0) && (q_due[i][0] <= cyc);
                fire  = t_req[i] && e_aok;
                pop   = e_dok;
                chk("addr_ok", 32'(w_aok[i]), 32'(e_aok));
                chk("data_ok", 32'(w_dok[i]), 32'(e_dok));
                if (e_dok) begin
                    chk("rdata", w_rdata[i], q_dat[i][0]);
                end else begin
                    chk("rdata_idle", w_rdata[i], 32'd0);
                end
`endif
                if (w_dok[i]) begin
                    n_pulse[i]++;
                    rlog[i].push_back(w_rdata[i]);
                    clog[i].push_back(cyc);
                end
                if (pop) begin
                    void'(q_due[i].pop_front());
                    void'(q_dat[i].pop_front());
                end
                if (fire) begin
                    n_acc[i]++;
                    idx = int'(t_addr[i][13:2]);
                    q_due[i].push_back(cyc + LAT[i]);
                    if (t_wr[i]) begin
                        q_dat[i].push_back(32'd0);
                        for (int b = 0; b < 4; b++) begin
                            if (t_wstrb[i][b]) ref_mem[i][idx][8*b +: 8] = t_wdata[i][8*b +: 8];
                        end
                    end else begin
                        q_dat[i].push_back(ref_mem[i][idx]);
                    end
                end
            end
        end
    end

    task automatic do_op(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        bit done;
        done       = 1'b0;
        t_req[i]   = 1'b1;
        t_wr[i]    = w;
        t_addr[i]  = a;
        t_wdata[i] = d;
        t_wstrb[i] = s;
        t_size[i]  = 2'($urandom_range(2, 0));
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            done = w_aok[i];
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic burst(input int i, input logic [31:0] a, input int n);
        int acc;
        acc        = 0;
        t_req[i]   = 1'b1;
        t_wr[i]    = 1'b0;
        t_addr[i]  = a;
        t_wstrb[i] = 4'h0;
        t_size[i]  = 2'd2;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            b_aok[k] = w_aok[i];
            b_dok[k] = w_dok[i];
            b_out[k] = int'(w_out[i]);
            if (t_req[i] && w_aok[i]) acc++;
            @(posedge clk);
            #1;
            if (acc == n) t_req[i] = 1'b0;
        end
        chk("burst_accepts", 32'(acc), 32'(n));
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < NI; i++) t_req[i] = 1'b0;
        for (int k = 0; k < 200 && !empty; k++) begin
            @(posedge clk);
            #1;
            empty = (q_due[0].size() == 0) && (q_due[1].size() == 0) && (q_due[2].size() == 0);
        end
        chk("drain_timeout", 32'(empty), 32'd1);
    endtask

    task automatic pulse_reset(input int ic);
        resetn = 1'b0;
        #1;
        chk("rst_addr_ok", 32'(w_aok[ic]), 32'd1);
        chk("rst_outstanding", 32'(w_out[ic]), 32'd0);
        chk("rst_data_ok", 32'(w_dok[ic]), 32'd0);
        chk("rst_rdata", w_rdata[ic], 32'd0);
        for (int i = 0; i < NI; i++) begin
            n_drop[i] += q_due[i].size();
            q_due[i].delete();
            q_dat[i].delete();
        end
        #1 resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < NI; i++) begin
            t_req[i] = 1'b0; t_wr[i] = 1'b0; t_size[i] = 2'd2; t_wstrb[i] = 4'h0;
            t_addr[i] = 32'd0; t_wdata[i] = 32'd0;
            n_acc[i] = 0; n_pulse[i] = 0; n_drop[i] = 0;
            for (int w = 0; w < 4096; w++) ref_mem[i][w] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("init_addr_ok", 32'(w_aok[i]), 32'd1);
            chk("init_data_ok", 32'(w_dok[i]), 32'd0);
            chk("init_rdata", w_rdata[i], 32'd0);
            chk("init_outstanding", 32'(w_out[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Write then read back at LATENCY=1.
        base = rlog[0].size();
        do_op(0, 1'b1, 32'h10, 32'h11223344, 4'hF);
        do_op(0, 1'b0, 32'h10, 32'h0, 4'h0);
        drain();
        chk("a_pulses", 32'(rlog[0].size() - base), 32'd2);
        chk("a_write_rdata", rlog[0][base], 32'h0);
        chk("a_read_rdata", rlog[0][base+1], 32'h11223344);
`ifndef DATA_SRAM_RANDOM_DELAY_EN
        chk("a_back_to_back", 32'(clog[0][base+1] - clog[0][base]), 32'd1);
`endif

        // Single-byte strobe merge.
        base = rlog[0].size();
        do_op(0, 1'b1, 32'h10, 32'h00AB0000, 4'b0100);
        do_op(0, 1'b0, 32'h12, 32'h0, 4'h0);
        drain();
        chk("b_merge_rdata", rlog[0][base+1], 32'h11AB3344);

        // Six held reads at LATENCY=3.
        do_op(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        drain();
        base = rlog[1].size();
        burst(1, 32'h20, 6);
        drain();
        chk("c_pulses", 32'(rlog[1].size() - base), 32'd6);
        chk("c_last_rdata", rlog[1][base+5], 32'hCAFEF00D);
`ifndef DATA_SRAM_RANDOM_DELAY_EN
        chk("c_no_early_pulse", 32'(b_dok[2]), 32'd0);
        chk("c_first_pulse", 32'(b_dok[3]), 32'd1);
        chk("c_steady_occupancy", 32'(b_out[4]), 32'd3);
`endif

        // Six held reads at LATENCY=5 fill the FIFO; no bypass when full.
        do_op(2, 1'b1, 32'h30, 32'h5A5AA5A5, 4'hF);
        drain();
        base = rlog[2].size();
        burst(2, 32'h30, 6);
        drain();
        chk("d_pulses", 32'(rlog[2].size() - base), 32'd6);
        chk("d_last_rdata", rlog[2][base+5], 32'h5A5AA5A5);
`ifndef DATA_SRAM_RANDOM_DELAY_EN
        chk("d_full_addr_ok", 32'(b_aok[4]), 32'd0);
        chk("d_full_pop_addr_ok", 32'(b_aok[5]), 32'd0);
        chk("d_full_pop_data_ok", 32'(b_dok[5]), 32'd1);
        chk("d_full_count", 32'(b_out[5]), 32'd4);
        chk("d_after_pop_count", 32'(b_out[6]), 32'd3);
        chk("d_after_pop_addr_ok", 32'(b_aok[6]), 32'd1);
`endif

        // Reset with three reads in flight drops their responses.
        do_op(2, 1'b0, 32'h30, 32'h0, 4'h0);
        do_op(2, 1'b0, 32'h30, 32'h0, 4'h0);
        do_op(2, 1'b0, 32'h30, 32'h0, 4'h0);
        t_req[2] = 1'b0;
        p = n_pulse[2];
        pulse_reset(2);
        repeat (12) @(posedge clk);
        #1;
        chk("e_no_pulse_after_reset", 32'(n_pulse[2] - p), 32'd0);

        // Random mixed traffic over eight words at LATENCY=3.
        for (int w = 0; w < 8; w++) begin
            do_op(1, 1'b1, 32'h100 + 32'(w * 4), 32'hA0000000 + 32'(w), 4'hF);
        end
        for (int n = 0; n < 200; n++) begin
            ra = 32'h100 + {27'd0, 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0))};
            do_op(1, 1'($urandom_range(1, 0)), ra, $urandom, 4'($urandom_range(15, 0)));
            if ($urandom_range(3, 0) == 0) begin
                t_req[1] = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drain();

        for (int i = 0; i < NI; i++) begin
            chk("pulse_balance", 32'(n_pulse[i]), 32'(n_acc[i] - n_drop[i]));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
